wash_sched: RTL and testbench

WASH_SCHED -- requirements
Module: wash_sched

---
 rtl/wash_sched.sv | 207 ++++++++++++++++++++
 tb/tb_wash_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wash_sched.sv
// Washing-machine program scheduler: sequences wash/rinse/spin phases on a 1 s tick,
// tracks remaining time in BCD and supports pause/door-open freeze.
module wash_sched #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic       door_closed,
  output logic [1:0] phase,
  output logic [3:0] action,
  output logic [3:0] rem_tens,
  output logic [3:0] rem_ones,
  output logic       busy,
  output logic       paused,
  output logic       done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [SW-1:0]  psec_q, psec_d;
  logic [3:0]     tens_q, tens_d;
  logic [3:0]     ones_q, ones_d;
  logic           paused_q, paused_d;
  logic [1:0]     phase_q, phase_d;
  logic [3:0]     action_q, action_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           running;
  logic           tick;
  logic [SW-1:0]  psec_inc;

  // Phase length in seconds for the latched program
  function automatic logic [SW-1:0] phase_len(input logic [1:0] m, input state_e s);
    logic [SW-1:0] len;
    len = '0;
    case (m)
      2'b00:   len = (s == S_SPIN) ? SW'(15) : SW'(0);
      2'b01:   len = SW'(10);
      2'b10:   len = SW'(15);
      default: len = SW'(20);
    endcase
    return len;
  endfunction

  function automatic logic [3:0] action_of(input state_e s, input logic [SW-1:0] k);
    logic [3:0]    act;
    logic [SW-1:0] k3;
    act = 4'd0;
    k3  = k % SW'(3);
    case (s)
      S_WASH:  act = k[0] ? 4'd2 : 4'd1;
      S_RINSE: begin
        case (k3)
          SW'(0):  act = 4'd3;
          SW'(1):  act = 4'd1;
          default: act = 4'd4;
        endcase
      end
      S_SPIN: begin
        case (k[1:0])
          2'd0:    act = 4'd5;
          2'd2:    act = 4'd6;
          default: act = 4'd4;
        endcase
      end
      S_DONE:  act = 4'd10;
      default: act = 4'd0;
    endcase
    return act;
  endfunction

  function automatic logic [1:0] phase_of(input state_e s);
    logic [1:0] ph;
    ph = 2'b00;
    case (s)
      S_WASH:  ph = 2'b01;
      S_RINSE: ph = 2'b10;
      S_SPIN:  ph = 2'b11;
      default: ph = 2'b00;
    endcase
    return ph;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      presc_q  <= '0;
      psec_q   <= '0;
      tens_q   <= 4'd6;
      ones_q   <= 4'd0;
      paused_q <= 1'b0;
      phase_q  <= 2'b00;
      action_q <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      psec_q   <= psec_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      paused_q <= paused_d;
      phase_q  <= phase_d;
      action_q <= action_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign running  = (state_q == S_WASH) || (state_q == S_RINSE) || (state_q == S_SPIN);
  assign tick     = running && !paused_q && (presc_q == PW'(TICK_DIV - 1));
  assign psec_inc = psec_q + SW'(1);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    psec_d   = psec_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    paused_d = paused_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && door_closed) begin
          mode_d   = mode;
          presc_d  = '0;
          psec_d   = '0;
          paused_d = 1'b0;
          state_d  = (mode == 2'b00) ? S_SPIN : S_WASH;
          case (mode)
            2'b00:   begin tens_d = 4'd1; ones_d = 4'd5; end
            2'b01:   begin tens_d = 4'd3; ones_d = 4'd0; end
            2'b10:   begin tens_d = 4'd4; ones_d = 4'd5; end
            default: begin tens_d = 4'd6; ones_d = 4'd0; end
          endcase
        end
      end
      default: begin
        if (!paused_q) begin
          if (tick) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (psec_inc == phase_len(mode_q, state_q)) begin
              psec_d = '0;
              case (state_q)
                S_WASH:  state_d = S_RINSE;
                S_RINSE: state_d = S_SPIN;
                default: state_d = S_DONE;
              endcase
            end else begin
              psec_d = psec_inc;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // Tick above is applied first; a pause request or open door then freezes
          if (pause || !door_closed) begin
            paused_d = 1'b1;
          end
        end else if (pause && door_closed) begin
          paused_d = 1'b0;
        end
        if (state_d == S_DONE) begin
          paused_d = 1'b0;
        end
      end
    endcase

    phase_d  = phase_of(state_d);
    action_d = action_of(state_d, psec_d);
    busy_d   = (state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_SPIN);
    done_d   = (state_d == S_DONE);
  end

  assign phase    = phase_q;
  assign action   = action_q;
  assign rem_tens = tens_q;
  assign rem_ones = ones_q;
  assign busy     = busy_q;
  assign paused   = paused_q;
  assign done     = done_q;

endmodule

// File: tb/tb_wash_sched.sv
// Directed bench for wash_sched with TICK_DIV=4 (one program second = 4 clk).
module tb_wash_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic [1:0] mode;
  logic       door_closed;
  logic [1:0] phase;
  logic [3:0] action;
  logic [3:0] rem_tens;
  logic [3:0] rem_ones;
  logic       busy;
  logic       paused;
  logic       done;

  int checks = 0;
  int errors = 0;

  wash_sched #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .mode        (mode),
    .door_closed (door_closed),
    .phase       (phase),
    .action      (action),
    .rem_tens    (rem_tens),
    .rem_ones    (rem_ones),
    .busy        (busy),
    .paused      (paused),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: {phase, action, rem_tens, rem_ones, busy, paused, done}
  task automatic chk_all(input string tag, input logic [1:0] ph, input logic [3:0] act,
                         input logic [7:0] rem, input logic b, input logic p, input logic d);
    chk({tag, ".phase"},  32'(phase), 32'(ph));
    chk({tag, ".action"}, 32'(action), 32'(act));
    chk({tag, ".rem"},    32'({rem_tens, rem_ones}), 32'(rem));
    chk({tag, ".busy"},   32'(busy), 32'(b));
    chk({tag, ".paused"}, 32'(paused), 32'(p));
    chk({tag, ".done"},   32'(done), 32'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'b00; door_closed = 1'b1;
    step(2);
    chk_all("reset", 2'b00, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1);

    // mode 01: 10/10/10
    mode = 2'b01; start = 1'b1;
    step(1); start = 1'b0;
    chk_all("m1_start", 2'b01, 4'd1, 8'h30, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m1_t1", 2'b01, 4'd2, 8'h29, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m1_t2", 2'b01, 4'd1, 8'h28, 1'b1, 1'b0, 1'b0);
    mode = 2'b11;
    step(32);
    chk_all("m1_t10", 2'b10, 4'd3, 8'h20, 1'b1, 1'b0, 1'b0);
    step(4);
    chk("m1_t11.action", 32'(action), 32'd1);
    step(4);
    chk("m1_t12.action", 32'(action), 32'd4);
    chk("m1_t12.rem", 32'({rem_tens, rem_ones}), 32'h18);
    step(28);
    chk_all("m1_t19", 2'b10, 4'd3, 8'h11, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m1_t20", 2'b11, 4'd5, 8'h10, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m1_t21", 2'b11, 4'd4, 8'h09, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step(1); start = 1'b0;
    chk_all("start_busy", 2'b11, 4'd4, 8'h09, 1'b1, 1'b0, 1'b0);
    step(34);
    chk_all("m1_t29", 2'b11, 4'd4, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("m1_done", 2'b00, 4'd10, 8'h00, 1'b0, 1'b0, 1'b1);
    step(5);
    chk("done_held", 32'(done), 32'd1);

    // start ignored with door open
    door_closed = 1'b0; mode = 2'b10; start = 1'b1;
    step(1); start = 1'b0;
    chk_all("start_door_open", 2'b00, 4'd10, 8'h00, 1'b0, 1'b0, 1'b1);
    step(2);
    chk("door_open_idle", 32'(busy), 32'd0);
    door_closed = 1'b1;

    // mode 00 spin-only; pause in same cycle as start must be ignored
    mode = 2'b00; start = 1'b1; pause = 1'b1;
    step(1); start = 1'b0; pause = 1'b0;
    chk_all("m0_start", 2'b11, 4'd5, 8'h15, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m0_t1", 2'b11, 4'd4, 8'h14, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m0_t2", 2'b11, 4'd6, 8'h13, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m0_t3", 2'b11, 4'd4, 8'h12, 1'b1, 1'b0, 1'b0);
    step(4);
    chk_all("m0_t4", 2'b11, 4'd5, 8'h11, 1'b1, 1'b0, 1'b0);
    step(43);
    chk_all("m0_t14", 2'b11, 4'd6, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("m0_done", 2'b00, 4'd10, 8'h00, 1'b0, 1'b0, 1'b1);

    // mode 11 with door-open freeze and pause handling
    mode = 2'b11; start = 1'b1;
    step(1); start = 1'b0;
    chk_all("m3_start", 2'b01, 4'd1, 8'h60, 1'b1, 1'b0, 1'b0);
    step(8);
    chk("m3_t2.rem", 32'({rem_tens, rem_ones}), 32'h58);
    step(2);
    door_closed = 1'b0;
    step(1);
    chk_all("door_freeze", 2'b01, 4'd1, 8'h58, 1'b1, 1'b1, 1'b0);
    step(10);
    chk_all("frozen", 2'b01, 4'd1, 8'h58, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    step(1); pause = 1'b0;
    chk("pause_door_open", 32'(paused), 32'd1);
    door_closed = 1'b1;
    step(3);
    chk("no_auto_resume", 32'(paused), 32'd1);
    chk("no_auto_resume.rem", 32'({rem_tens, rem_ones}), 32'h58);
    pause = 1'b1;
    step(1); pause = 1'b0;
    chk("resumed", 32'(paused), 32'd0);
    step(1);
    chk_all("m3_t3", 2'b01, 4'd2, 8'h57, 1'b1, 1'b0, 1'b0);
    step(3);
    pause = 1'b1;
    step(1); pause = 1'b0;
    chk_all("tick_then_pause", 2'b01, 4'd1, 8'h56, 1'b1, 1'b1, 1'b0);
    pause = 1'b1;
    step(1); pause = 1'b0;
    chk("resume2", 32'(paused), 32'd0);
    step(223);
    chk_all("m3_t59", 2'b11, 4'd4, 8'h01, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("m3_done", 2'b00, 4'd10, 8'h00, 1'b0, 1'b0, 1'b1);

    // asynchronous reset in the middle of RINSE
    mode = 2'b01; start = 1'b1;
    step(1); start = 1'b0;
    step(48);
    chk("m1b_rinse.phase", 32'(phase), 32'd2);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'b00, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(2);
    chk_all("post_rst", 2'b00, 4'd0, 8'h60, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
